rr_arbiter: RTL and testbench

Parametrised round-robin arbiter for N requesters, generalising the two-requester request/grant arbitration interface to N channels.
- Grants are registered one-hot, with an encoded index.
- Grant is held while the owner keeps requesting, with optional fair preemption after MAX_HOLD cycles and a lock override.
- Sits between bus masters and a shared resource in the test-bench/RTL hierarchy.

---
 rtl/rr_arb_pkg.sv | 12 +
 rtl/rr_pick.sv | 44 ++++
 rtl/rr_arbiter.sv | 116 +++++++++++
 tb/tb_rr_arbiter.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter (rr_arbiter, rr_pick).
package rr_arb_pkg;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_t;

  localparam int CNT_W = 16;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Circular priority encoder: lowest-index eligible request at or above ptr,
// wrapping to index 0; mask_en removes mask_idx from the search.
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic [IDX_W-1:0] mask_idx,
  input  logic             mask_en,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic             hi_found;
  logic             lo_found;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;

  // Scan downward so the last hit written is the lowest index; the "hi" set
  // covers ptr..N-1 and wins over the wrapped "lo" set.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && !(mask_en && (mask_idx == IDX_W'(i)))) begin
        lo_found = 1'b1;
        lo_idx   = IDX_W'(i);
        if (i >= int'(ptr)) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(i);
        end
      end
    end
  end

  assign found = hi_found | lo_found;
  assign idx   = hi_found ? hi_idx : lo_idx;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for N requesters with hold-time preemption and lock.
// Optional per-requester acquisition counters under RR_ARBITER_STATS_EN.
module rr_arbiter
  import rr_arb_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = 8,
  parameter  int HOLD_W   = 8,
  localparam int IDX_W    = idx_w(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         request,
  input  logic                 lock,
  output logic [N-1:0]         grant,
  output logic                 grant_valid,
  output logic [IDX_W-1:0]     grant_idx,
`ifdef RR_ARBITER_STATS_EN
  output logic [N*CNT_W-1:0]   grant_cnt,
`endif
  output arb_state_t           dbg_state
);

  // Handshake: request[i] is a level held until the requester is done; grant[i]
  // rises one cycle after sampling and stays while request[i] stays high,
  // unless a fair preemption (hold limit reached, lock low, others waiting) fires.

  arb_state_t       state;
  logic [IDX_W-1:0] ptr;
  logic [HOLD_W-1:0] hold_cnt;

  logic             owner_req;
  logic [IDX_W-1:0] next_o;
  logic [IDX_W-1:0] pick_ptr;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             do_release;
  logic             do_preempt;
  logic             acquire;

  assign owner_req = |(request & grant);
  assign next_o    = (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
  assign pick_ptr  = (state == BUSY) ? next_o : ptr;

  rr_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
    .req      (request),
    .ptr      (pick_ptr),
    .mask_idx (grant_idx),
    .mask_en  (state == BUSY),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  always_comb begin
    do_release = 1'b0;
    do_preempt = 1'b0;
    acquire    = 1'b0;
    if (state == IDLE) begin
      acquire = pick_found;
    end else begin
      do_release = !owner_req;
      do_preempt = owner_req && (MAX_HOLD != 0) && (hold_cnt >= HOLD_W'(MAX_HOLD))
                   && !lock && pick_found;
      acquire    = (do_release || do_preempt) && pick_found;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
    end else begin
      if (do_release || do_preempt) ptr <= next_o;
      if (acquire) begin
        state       <= BUSY;
        grant       <= N'(1) << pick_idx;
        grant_valid <= 1'b1;
        grant_idx   <= pick_idx;
        hold_cnt    <= HOLD_W'(1);
      end else if (do_release) begin
        // grant_idx keeps the last owner while idle
        state       <= IDLE;
        grant       <= '0;
        grant_valid <= 1'b0;
        hold_cnt    <= '0;
      end else if (state == BUSY && hold_cnt != '1) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  assign dbg_state = state;

`ifdef RR_ARBITER_STATS_EN
  logic [CNT_W-1:0] cnt_q [N];

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        cnt_q[i] <= '0;
      end else if (acquire && pick_idx == IDX_W'(i) && cnt_q[i] != '1) begin
        cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_cnt
    assign grant_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter (N=4, MAX_HOLD=4, HOLD_W=8); define
// RR_ARBITER_STATS_EN to also exercise the acquisition counters.
module tb_rr_arbiter;
  import rr_arb_pkg::*;

  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     request;
  logic             lock;
  logic [N-1:0]     grant;
  logic             grant_valid;
  logic [1:0]       grant_idx;
  arb_state_t       dbg_state;
`ifdef RR_ARBITER_STATS_EN
  logic [N*16-1:0]  grant_cnt;
`endif

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  rr_arbiter #(.N(N), .MAX_HOLD(4), .HOLD_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .request     (request),
    .lock        (lock),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
`ifdef RR_ARBITER_STATS_EN
    .grant_cnt   (grant_cnt),
`endif
    .dbg_state   (dbg_state)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] g, input logic gv,
                           input logic [1:0] gi);
    check({tag, "_grant"}, 32'(grant), 32'(g));
    check({tag, "_valid"}, 32'(grant_valid), 32'(gv));
    check({tag, "_idx"}, 32'(grant_idx), 32'(gi));
  endtask

  logic [3:0] exp_g;

  initial begin
    rst = 1'b1; request = '0; lock = 1'b0;
    tick(2);
    check_out("reset", 4'b0000, 1'b0, 2'd0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));

    // 1: grant after one cycle, handover without idle bubble, then idle
    rst = 1'b0; request = 4'b1010;
    tick(1);
    check_out("first", 4'b0010, 1'b1, 2'd1);
    request = 4'b1000;
    tick(1);
    check_out("handover", 4'b1000, 1'b1, 2'd3);
    request = 4'b0000;
    tick(1);
    check_out("to_idle", 4'b0000, 1'b0, 2'd3);
    check("to_idle_state", 32'(dbg_state), 32'(IDLE));

    // 2: full contention rotates every MAX_HOLD cycles (ptr is 0 here)
    request = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      exp_g = 4'b0001 << ((c / 4) % 4);
      check("rotate", 32'(grant), 32'(exp_g));
    end
    request = 4'b0000;
    tick(1);
    check("rotate_idle", 32'(grant_valid), 32'd0);

    // 3: sole requester keeps grant past the hold limit (ptr is 1 here)
    request = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      check("solo_grant", 32'(grant), 32'h1);
      check("solo_valid", 32'(grant_valid), 32'd1);
    end
    request = 4'b0000;
    tick(1);
    check("solo_idle", 32'(grant), 32'h0);

    // 4: lock blocks preemption; releasing lock preempts on the next edge
    request = 4'b0100;
    tick(1);
    check_out("lock_own", 4'b0100, 1'b1, 2'd2);
    request = 4'b0101; lock = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick(1);
      check("lock_hold", 32'(grant), 32'h4);
    end
    lock = 1'b0;
    tick(1);
    check_out("unlock_preempt", 4'b0001, 1'b1, 2'd0);

    // 5: reset mid-grant, then ptr restarts at 0
    request = 4'b0100;
    tick(1);
    check_out("pre_rst", 4'b0100, 1'b1, 2'd2);
    rst = 1'b1;
    tick(1);
    check_out("mid_rst", 4'b0000, 1'b0, 2'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0; request = 4'b1100;
    tick(1);
    check_out("post_rst", 4'b0100, 1'b1, 2'd2);

`ifdef RR_ARBITER_STATS_EN
    // 6: eight acquisitions in 32 cycles of full contention -> two each
    rst = 1'b1; request = 4'b0000;
    tick(1);
    check("cnt_clear", 32'(grant_cnt[15:0]), 32'd0);
    rst = 1'b0; request = 4'b1111;
    tick(32);
    request = 4'b0000;
    check("cnt0", 32'(grant_cnt[15:0]), 32'd2);
    check("cnt1", 32'(grant_cnt[31:16]), 32'd2);
    check("cnt2", 32'(grant_cnt[47:32]), 32'd2);
    check("cnt3", 32'(grant_cnt[63:48]), 32'd2);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
